// File: rtl/miner_pkg.sv
// Shared types and helpers for the multi-core mining controller.
package miner_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    IDLE,
    LOAD_TARGET,
    LOAD_MSG,
    CLEAR,
    SEARCH,
    RESULT,
    ERROR
  } ctrl_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int core_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lowest_set_picker.sv
// Priority picker: reports whether any bit is set and the index of the lowest one.
module lowest_set_picker
  import miner_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int IDX_W = core_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    found = |vec;
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/multi_core_controller.sv
// Mining controller: hands out nonces to NUM_CORES SHA cores one per cycle,
// tracks each core's nonce and reports the lowest-index winning core.
module multi_core_controller
  import miner_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W = 32,
  localparam int CORE_W = core_w(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 newTarget,
  input  logic                 newMsg,
  input  logic                 abort,
  input  logic [NUM_CORES-1:0] complete,
  input  logic [NUM_CORES-1:0] valid,
  output logic                 loadTarget,
  output logic                 loadMsg,
  output logic                 clearCores,
  output logic [NUM_CORES-1:0] beginSHA,
  output logic [NONCE_W-1:0]   nonceOut,
  output logic                 loadResults,
  output logic [NONCE_W-1:0]   resultNonce,
  output logic [CORE_W-1:0]    resultCore,
  output logic                 busy,
  output logic                 error
);

  ctrl_state_t state_reg, state_next;
  // Set when CLEAR was entered through an abort, so CLEAR returns to IDLE.
  logic abort_reg, abort_next;
  logic [NUM_CORES-1:0] core_busy_reg, core_busy_next;
  logic [NONCE_W-1:0] counter_reg, counter_next;
  logic exhausted_reg, exhausted_next;
  logic [NONCE_W-1:0] last_nonce_reg;
  logic [NONCE_W-1:0] core_nonce_reg [NUM_CORES];
  logic [NONCE_W-1:0] result_nonce_reg;
  logic [CORE_W-1:0] result_core_reg;

  logic disp_found, win_found;
  logic [CORE_W-1:0] disp_idx, win_idx;
  logic [NUM_CORES-1:0] disp_onehot;
  logic dispatch, capture;

  // Lowest idle core gets the next nonce.
  lowest_set_picker #(.WIDTH(NUM_CORES)) u_free_picker (
    .vec   (~core_busy_reg),
    .found (disp_found),
    .index (disp_idx)
  );

  // Lowest busy core reporting a valid hash wins.
  lowest_set_picker #(.WIDTH(NUM_CORES)) u_win_picker (
    .vec   (complete & valid & core_busy_reg),
    .found (win_found),
    .index (win_idx)
  );

  assign disp_onehot = NUM_CORES'(1) << disp_idx;
  assign beginSHA    = dispatch ? disp_onehot : '0;
  assign nonceOut    = dispatch ? counter_reg : last_nonce_reg;
  assign resultNonce = result_nonce_reg;
  assign resultCore  = result_core_reg;

  // Next-state, bookkeeping updates and state-decoded strobes.
  always_comb begin
    state_next     = state_reg;
    abort_next     = abort_reg;
    core_busy_next = core_busy_reg;
    counter_next   = counter_reg;
    exhausted_next = exhausted_reg;
    dispatch       = 1'b0;
    capture        = 1'b0;
    loadTarget     = 1'b0;
    loadMsg        = 1'b0;
    clearCores     = 1'b0;
    loadResults    = 1'b0;
    busy           = 1'b0;
    error          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (newTarget) begin
          state_next = LOAD_TARGET;
        end else if (newMsg) begin
          state_next = LOAD_MSG;
        end
      end
      LOAD_TARGET: begin
        loadTarget = 1'b1;
        state_next = IDLE;
      end
      LOAD_MSG: begin
        loadMsg    = 1'b1;
        abort_next = 1'b0;
        state_next = CLEAR;
      end
      CLEAR: begin
        clearCores     = 1'b1;
        counter_next   = '0;
        exhausted_next = 1'b0;
        core_busy_next = '0;
        abort_next     = 1'b0;
        state_next     = abort_reg ? IDLE : SEARCH;
      end
      SEARCH: begin
        busy           = 1'b1;
        // Completions from idle cores fall out naturally: their bit is already 0.
        core_busy_next = core_busy_reg & ~complete;
        if (newMsg) begin
          state_next = LOAD_MSG;
        end else if (abort) begin
          abort_next = 1'b1;
          state_next = CLEAR;
        end else if (win_found) begin
          capture    = 1'b1;
          state_next = RESULT;
        end else begin
          if (exhausted_reg && (core_busy_reg == '0)) begin
            state_next = ERROR;
          end
          if (disp_found && !exhausted_reg) begin
            dispatch       = 1'b1;
            core_busy_next = core_busy_next | disp_onehot;
            counter_next   = counter_reg + 1'b1;
            if (counter_reg == {NONCE_W{1'b1}}) begin
              exhausted_next = 1'b1;
            end
          end
        end
      end
      RESULT: begin
        loadResults    = 1'b1;
        clearCores     = 1'b1;
        core_busy_next = '0;
        state_next     = IDLE;
      end
      ERROR: begin
        error = 1'b1;
        if (newTarget) begin
          state_next = LOAD_TARGET;
        end else if (newMsg) begin
          state_next = LOAD_MSG;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Controller state, nonce counter and result registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg        <= IDLE;
      abort_reg        <= 1'b0;
      core_busy_reg    <= '0;
      counter_reg      <= '0;
      exhausted_reg    <= 1'b0;
      last_nonce_reg   <= '0;
      result_nonce_reg <= '0;
      result_core_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      abort_reg     <= abort_next;
      core_busy_reg <= core_busy_next;
      counter_reg   <= counter_next;
      exhausted_reg <= exhausted_next;
      if (dispatch) begin
        last_nonce_reg <= counter_reg;
      end
      if (capture) begin
        result_nonce_reg <= core_nonce_reg[win_idx];
        result_core_reg  <= win_idx;
      end
    end
  end

  // Per-core record of the nonce each core is currently hashing.
  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core_nonce
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          core_nonce_reg[gi] <= '0;
        end else if (dispatch && disp_onehot[gi]) begin
          core_nonce_reg[gi] <= counter_reg;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_multi_core_controller.sv
// Directed bench for multi_core_controller (4 cores, 4-bit nonce space).
module tb_multi_core_controller;

  localparam int NC = 4;
  localparam int NW = 4;
  localparam int CW = 2;
  localparam int NV = 28;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic newTarget = 1'b0, newMsg = 1'b0, abort = 1'b0;
  logic [NC-1:0] complete = '0, valid = '0;
  logic loadTarget, loadMsg, clearCores, loadResults, busy, error;
  logic [NC-1:0] beginSHA;
  logic [NW-1:0] nonceOut, resultNonce;
  logic [CW-1:0] resultCore;

  int n_checks = 0;
  int n_fail = 0;

  multi_core_controller #(.NUM_CORES(NC), .NONCE_W(NW)) dut (
    .clk(clk), .n_rst(n_rst), .newTarget(newTarget), .newMsg(newMsg), .abort(abort),
    .complete(complete), .valid(valid), .loadTarget(loadTarget), .loadMsg(loadMsg),
    .clearCores(clearCores), .beginSHA(beginSHA), .nonceOut(nonceOut),
    .loadResults(loadResults), .resultNonce(resultNonce), .resultCore(resultCore),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic nt, nm, ab;
    logic [3:0] cmp, vld;
    logic ltg, lmsg, clr, lres, bsy, err;
    logic [3:0] beg, non;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic nt, nm, ab, input logic [3:0] cmp, vld,
                              input logic ltg, lmsg, clr, lres, bsy, err,
                              input logic [3:0] beg, non);
    vec_t v;
    v.nt = nt; v.nm = nm; v.ab = ab; v.cmp = cmp; v.vld = vld;
    v.ltg = ltg; v.lmsg = lmsg; v.clr = clr; v.lres = lres; v.bsy = bsy; v.err = err;
    v.beg = beg; v.non = non;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {loadTarget, loadMsg, clearCores, loadResults, busy, error, beginSHA, nonceOut};
  endfunction

  logic [13:0] exp_o;
  int disp;
  int cyc;
  logic seen_err;

  initial begin
    // nt nm ab cmp vld | ltg lmsg clr lres bsy err | beg non
    vecs[0]  = mk(1,1,0,4'h0,4'h0, 0,0,0,0,0,0, 4'h0,4'h0); // both strobes: target wins
    vecs[1]  = mk(0,0,0,4'h0,4'h0, 1,0,0,0,0,0, 4'h0,4'h0);
    vecs[2]  = mk(0,0,0,4'h0,4'h0, 0,0,0,0,0,0, 4'h0,4'h0);
    vecs[3]  = mk(1,0,0,4'h0,4'h0, 0,0,0,0,0,0, 4'h0,4'h0);
    vecs[4]  = mk(0,0,0,4'h0,4'h0, 1,0,0,0,0,0, 4'h0,4'h0);
    vecs[5]  = mk(0,1,0,4'h0,4'h0, 0,0,0,0,0,0, 4'h0,4'h0);
    vecs[6]  = mk(0,0,0,4'h0,4'h0, 0,1,0,0,0,0, 4'h0,4'h0);
    vecs[7]  = mk(0,0,0,4'h0,4'h0, 0,0,1,0,0,0, 4'h0,4'h0);
    vecs[8]  = mk(0,0,0,4'h0,4'h0, 0,0,0,0,1,0, 4'h1,4'h0);
    vecs[9]  = mk(0,0,0,4'h0,4'h0, 0,0,0,0,1,0, 4'h2,4'h1);
    vecs[10] = mk(0,0,0,4'h0,4'h0, 0,0,0,0,1,0, 4'h4,4'h2);
    vecs[11] = mk(0,0,0,4'h0,4'h0, 0,0,0,0,1,0, 4'h8,4'h3);
    vecs[12] = mk(1,0,0,4'h4,4'h0, 0,0,0,0,1,0, 4'h0,4'h3); // core 2 done; newTarget ignored
    vecs[13] = mk(0,0,0,4'h0,4'h0, 0,0,0,0,1,0, 4'h4,4'h4);
    vecs[14] = mk(0,0,0,4'h6,4'h6, 0,0,0,0,1,0, 4'h0,4'h4); // cores 1,2 win: core 1
    vecs[15] = mk(0,0,0,4'h0,4'h0, 0,0,1,1,0,0, 4'h0,4'h4);
    vecs[16] = mk(0,0,0,4'h0,4'h0, 0,0,0,0,0,0, 4'h0,4'h4);
    vecs[17] = mk(0,1,0,4'h0,4'h0, 0,0,0,0,0,0, 4'h0,4'h4);
    vecs[18] = mk(0,0,0,4'h0,4'h0, 0,1,0,0,0,0, 4'h0,4'h4);
    vecs[19] = mk(0,0,0,4'h0,4'h0, 0,0,1,0,0,0, 4'h0,4'h4);
    vecs[20] = mk(0,0,0,4'h0,4'h0, 0,0,0,0,1,0, 4'h1,4'h0);
    vecs[21] = mk(0,0,0,4'h0,4'h0, 0,0,0,0,1,0, 4'h2,4'h1);
    vecs[22] = mk(0,0,0,4'h0,4'h0, 0,0,0,0,1,0, 4'h4,4'h2);
    vecs[23] = mk(0,0,0,4'h0,4'h0, 0,0,0,0,1,0, 4'h8,4'h3);
    vecs[24] = mk(0,0,1,4'h0,4'h0, 0,0,0,0,1,0, 4'h0,4'h3); // abort
    vecs[25] = mk(0,0,0,4'h0,4'h0, 0,0,1,0,0,0, 4'h0,4'h3);
    vecs[26] = mk(0,0,0,4'h0,4'h0, 0,0,0,0,0,0, 4'h0,4'h3);
    vecs[27] = mk(0,0,0,4'h0,4'h0, 0,0,0,0,0,0, 4'h0,4'h3);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {outs(), resultNonce, resultCore}, 32'h0);
    n_rst = 1'b1;

    // Table-driven part: one row per cycle
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      newTarget = vecs[i].nt; newMsg = vecs[i].nm; abort = vecs[i].ab;
      complete = vecs[i].cmp; valid = vecs[i].vld;
      @(negedge clk);
      exp_o = {vecs[i].ltg, vecs[i].lmsg, vecs[i].clr, vecs[i].lres,
               vecs[i].bsy, vecs[i].err, vecs[i].beg, vecs[i].non};
      $display("row %0d: outs=%h exp=%h", i, outs(), exp_o);
      chk($sformatf("row%0d", i), outs(), exp_o);
      if (i == 16) begin
        chk("result_nonce_win", resultNonce, 1);
        chk("result_core_win", resultCore, 1);
      end
    end
    chk("result_nonce_after_abort", resultNonce, 1);
    chk("result_core_after_abort", resultCore, 1);

    // Exhaustion: complete every core every cycle, never valid
    @(posedge clk); #1 newMsg = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 newMsg = 1'b0;
    @(negedge clk); chk("exh_loadmsg", loadMsg, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("exh_clear", clearCores, 1);
    @(posedge clk); #1 complete = 4'hF;
    disp = 0; cyc = 0; seen_err = 1'b0;
    while (cyc < 60) begin
      @(negedge clk);
      if (error) begin
        seen_err = 1'b1;
        break;
      end
      if (beginSHA != '0) begin
        $display("dispatch %0d: core mask %b nonce %0d", disp, beginSHA, nonceOut);
        chk($sformatf("exh_nonce%0d", disp), nonceOut, disp);
        chk($sformatf("exh_core%0d", disp), beginSHA, (disp % 2 == 1) ? 4'h2 : 4'h1);
        disp++;
      end
      cyc++;
    end
    chk("exh_error_reached", seen_err, 1);
    chk("exh_dispatch_count", disp, 16);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("exh_error_held", {error, beginSHA}, 5'h10);
    end
    @(posedge clk); #1 complete = '0; newMsg = 1'b1;
    @(negedge clk); chk("err_before_exit", error, 1);
    @(posedge clk); #1 newMsg = 1'b0;
    @(negedge clk); chk("err_exit_loadmsg", {error, loadMsg}, 2'b01);
    @(negedge clk); chk("err_exit_clear", clearCores, 1);
    @(negedge clk); chk("restart_first", {busy, beginSHA, nonceOut}, {1'b1, 4'h1, 4'h0});
    @(negedge clk); chk("restart_second", {busy, beginSHA, nonceOut}, {1'b1, 4'h2, 4'h1});

    // Asynchronous reset mid-search
    #2 n_rst = 1'b0;
    #1;
    chk("async_reset_outputs", {outs(), resultNonce, resultCore}, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1 newMsg = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 newMsg = 1'b0;
    @(negedge clk); chk("post_reset_loadmsg", loadMsg, 1);
    @(negedge clk); chk("post_reset_clear", clearCores, 1);
    @(negedge clk); chk("post_reset_first", {busy, beginSHA, nonceOut}, {1'b1, 4'h1, 4'h0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_core_controller.md
Name: multi_core_controller

Overview:
Top-level mining controller for the bitcoin miner. It drives NUM_CORES parallel SHA cores instead of one.
- Owns the nonce counter and hands out nonces to idle cores, one dispatch per cycle.
- Tracks which nonce each core is hashing and reports the winning nonce and its core.
- Flags exhaustion of the nonce space.
- Sits between the host interface (target/message load strobes) and the SHA core array.

Parameters:
NUM_CORES, 4, number of SHA cores driven (>=1)
NONCE_W, 32, nonce width in bits; the search space is 0 .. 2^NONCE_W-1
CORE_W, max(1,$clog2(NUM_CORES)), core index width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
newTarget  in  1  pulse: host has a new target
newMsg  in  1  pulse: host has a new message; starts or restarts a search
abort  in  1  pulse: stop the current search without a result
complete  in  NUM_CORES  per-core hash-done pulse
valid  in  NUM_CORES  per-core hash<target flag, qualified by complete
loadTarget  out  1  target register load strobe
loadMsg  out  1  message register load strobe
clearCores  out  1  synchronous clear to all cores
beginSHA  out  NUM_CORES  one-hot start strobe; the core latches nonceOut on it
nonceOut  out  NONCE_W  nonce for the core being started
loadResults  out  1  result register load strobe
resultNonce  out  NONCE_W  winning nonce
resultCore  out  CORE_W  index of the winning core
busy  out  1  high while in SEARCH
error  out  1  nonce space exhausted with no valid hash

Behaviour:
- Reset (n_rst low, asynchronous): state IDLE; all outputs 0; coreBusy, nonce counter, exhausted flag, per-core nonce registers, resultNonce and resultCore all cleared.
- All strobes are decoded from the registered state. A strobe is high exactly one cycle, the cycle after the causing input is sampled.
- States: IDLE, LOAD_TARGET, LOAD_MSG, CLEAR, SEARCH, RESULT, ERROR.
- IDLE:
  - newTarget -> LOAD_TARGET; else newMsg -> LOAD_MSG.
  - If both are high together, newTarget wins and newMsg is dropped.
- LOAD_TARGET: loadTarget=1 -> IDLE.
- LOAD_MSG: loadMsg=1 -> CLEAR.
- CLEAR: clearCores=1; counter<=0, exhausted<=0, coreBusy<=0 -> SEARCH.
- SEARCH (busy=1): dispatch rule.
  - If some coreBusy[i]=0 and exhausted=0, pick the lowest such i.
  - Drive beginSHA[i]=1 and nonceOut=counter this cycle.
  - Update: coreNonce[i]<=counter, coreBusy[i]<=1, counter<=counter+1.
  - Dispatching 2^NONCE_W-1 sets exhausted; the counter wrap value is don't-care after that.
  - When not dispatching: beginSHA=0 and nonceOut holds its last value.
- SEARCH: completion rule.
  - complete[i] with coreBusy[i]=1 clears coreBusy[i] at the edge.
  - The freed core is re-dispatchable from the following cycle; dispatch uses registered coreBusy.
  - complete from a non-busy core, or outside SEARCH, is ignored.
- SEARCH: winner rule.
  - If any busy i has complete[i]&valid[i], pick the lowest such index.
  - Capture resultNonce<=coreNonce[i] and resultCore<=i -> RESULT. No dispatch occurs in that cycle.
- SEARCH: exit priority (highest first):
  1. newMsg -> LOAD_MSG (restart).
  2. abort -> CLEAR then IDLE. Implement with a one-cycle clearCores in IDLE entry; loadResults is not asserted.
  3. Valid winner -> RESULT.
  4. exhausted=1 and coreBusy==0 -> ERROR.
- newTarget in SEARCH is ignored.
- RESULT: loadResults=1 and clearCores=1 for one cycle; coreBusy<=0 -> IDLE.
  - resultNonce/resultCore are held until the next winner or reset.
- ERROR: error=1, held.
  - newTarget -> LOAD_TARGET; else newMsg -> LOAD_MSG.
  - error drops on exit.
- Exhaustion with a core still busy: keep waiting. A late valid still wins.
- NUM_CORES=1 degenerates to the single-core sequence: beginSHA, wait complete, increment, re-begin.

Decomposition:
- Package miner_pkg holds:
  - the state enum typedef (ctrl_state_t);
  - a function core_w(n) returning max(1,$clog2(n)).
- Sub-module lowest_set_picker (parameter WIDTH): input a vector; outputs found and the lowest set index.
- Instantiate it twice: once on ~coreBusy for dispatch, once on complete&valid&coreBusy for the winner.

Test Plan:
- Reset, pulse newTarget -> loadTarget=1 one cycle after, all other outputs 0; pulse newMsg -> loadMsg next cycle, clearCores the cycle after.
- NUM_CORES=4, after CLEAR -> four consecutive cycles with beginSHA=0001,0010,0100,1000 and nonceOut=0,1,2,3; busy=1.
- complete=0100, valid=0 -> core 2 re-dispatched the next cycle with nonceOut=4. Then complete=0110 and valid=0110 in one cycle -> resultCore=1, resultNonce=core1's nonce, loadResults and clearCores high one cycle, then IDLE.
- NONCE_W=4, never assert valid, complete every busy core each cycle -> exactly 16 dispatches (nonces 0..15), then error=1 held. A newMsg clears error and restarts at nonce 0.
- Mid-SEARCH abort -> clearCores one cycle, IDLE, loadResults never asserted, resultNonce unchanged.
- Mid-SEARCH n_rst low asynchronously -> all outputs 0 immediately. After release, a newMsg starts dispatch at nonce 0 on core 0.
